io_trace_capture: RTL and testbench



---
 rtl/io_trace_capture.sv | 188 ++++++++++++++++++
 tb/tb_io_trace_capture.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_trace_capture.sv
// io_trace_capture: timestamps changes on masked io_out pads into a FIFO read over Wishbone.
// Define IO_TRACE_TRIGGER_EN to add the ARMED state and the TRIG_MASK/TRIG_VAL pattern trigger.
module io_trace_capture #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0600,
  parameter int          PADS      = 38,
  parameter int          DEPTH     = 16,
  parameter int          TS_WIDTH  = 26
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [PADS-1:0] io_sample,
  output logic            capturing
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

`ifdef IO_TRACE_TRIGGER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, ARMED = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1} state_t;
`endif

  state_t state, state_nxt;

  logic                enable;
  logic [PADS-1:0]     mask;
  logic [PADS-1:0]     prev;
  logic [TS_WIDTH-1:0] ts;
  logic [63:0]         mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                overflow;
  logic                busy;
`ifdef IO_TRACE_TRIGGER_EN
  logic [31:0]         trig_mask, trig_val;
  logic                trig_hit;
`endif

  logic [7:0]      offset;
  logic            in_window, mapped, accept, wr_ok;
  logic            do_clear, pop_req, do_pop, push_req, do_push;
  logic            empty, full;
  logic [PADS-1:0] chg;
  logic [63:0]     entry, head;
  logic [31:0]     rd_data;

  assign offset    = wbs_adr_i[7:0];
  assign in_window = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);

  always_comb begin
    mapped = 1'b0;
    case (offset)
      8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14: mapped = in_window;
`ifdef IO_TRACE_TRIGGER_EN
      8'h18, 8'h1C: mapped = in_window;
`endif
      default: mapped = 1'b0;
    endcase
  end

  // busy holds off re-acceptance until the master drops its strobe
  assign accept   = wbs_cyc_i & wbs_stb_i & ~busy & mapped;
  assign wr_ok    = accept & wbs_we_i & (wbs_sel_i == 4'hF);
  assign do_clear = wr_ok & (offset == 8'h00) & wbs_dat_i[1];
  assign pop_req  = accept & ~wbs_we_i & (offset == 8'h14);

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign chg      = (io_sample ^ prev) & mask;
  assign push_req = (state == CAPTURE) && (chg != '0) && !do_clear;
  assign do_pop   = pop_req && !empty;
  assign do_push  = push_req && (!full || do_pop);
  assign entry    = 64'({ts, io_sample});
  assign head     = empty ? '0 : mem[rd_ptr];

  assign capturing = (state == CAPTURE);

`ifdef IO_TRACE_TRIGGER_EN
  assign trig_hit = ((io_sample[31:0] ^ trig_val) & trig_mask) == '0;
`endif

  always_comb begin
    rd_data = '0;
    case (offset)
      8'h00: rd_data = {31'd0, enable};
      8'h04: rd_data = mask[31:0];
      8'h08: rd_data = 32'(mask[PADS-1:32]);
      8'h0C: rd_data = {13'd0, overflow, full, empty, 9'd0, 7'(count)};
      8'h10: rd_data = head[31:0];
      8'h14: rd_data = head[63:32];
`ifdef IO_TRACE_TRIGGER_EN
      8'h18: rd_data = trig_mask;
      8'h1C: rd_data = trig_val;
`endif
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef IO_TRACE_TRIGGER_EN
      IDLE:    if (enable) state_nxt = ARMED;
      ARMED:   if (!enable) state_nxt = IDLE;
               else if (trig_hit) state_nxt = CAPTURE;
`else
      IDLE:    if (enable) state_nxt = CAPTURE;
`endif
      CAPTURE: if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      busy      <= 1'b0;
      enable    <= 1'b0;
      mask      <= '0;
`ifdef IO_TRACE_TRIGGER_EN
      trig_mask <= '0;
      trig_val  <= '0;
`endif
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= (accept && !wbs_we_i) ? rd_data : '0;
      if (accept) busy <= 1'b1;
      else if (!(wbs_cyc_i && wbs_stb_i)) busy <= 1'b0;
      if (wr_ok) begin
        case (offset)
          8'h00: enable <= wbs_dat_i[0];
          8'h04: mask[31:0] <= wbs_dat_i;
          8'h08: mask[PADS-1:32] <= wbs_dat_i[PADS-33:0];
`ifdef IO_TRACE_TRIGGER_EN
          8'h18: trig_mask <= wbs_dat_i;
          8'h1C: trig_val <= wbs_dat_i;
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      prev     <= '0;
      ts       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      prev  <= io_sample;
      if (((state != CAPTURE) && (state_nxt == CAPTURE)) || do_clear) ts <= '0;
      else if (state == CAPTURE) ts <= ts + 1'b1;
      if (do_clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        if (do_push && !do_pop) count <= count + 1'b1;
        else if (!do_push && do_pop) count <= count - 1'b1;
        // a full-FIFO push only survives when the same cycle frees a slot
        if (push_req && !do_push) overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem[wr_ptr] <= entry;
  end

endmodule

// File: tb/tb_io_trace_capture.sv
// Self-checking bench for io_trace_capture: directed scenarios plus random pad activity
// scored cycle by cycle against a queue-based model of the capture rules.
module tb_io_trace_capture;

  localparam logic [31:0] BASE_ADDR = 32'h3000_0600;
  localparam int PADS = 38;
  localparam int DEPTH = 16;
  localparam int TS_WIDTH = 26;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i = 1'b1;
  logic            wbs_stb_i = 1'b0;
  logic            wbs_cyc_i = 1'b0;
  logic            wbs_we_i = 1'b0;
  logic [3:0]      wbs_sel_i = 4'hF;
  logic [31:0]     wbs_adr_i = '0;
  logic [31:0]     wbs_dat_i = '0;
  logic            wbs_ack_o;
  logic [31:0]     wbs_dat_o;
  logic [PADS-1:0] io_sample = '0;
  logic            capturing;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 0;

  io_trace_capture #(
    .BASE_ADDR(BASE_ADDR), .PADS(PADS), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .io_sample(io_sample), .capturing(capturing)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO is a queue, timestamp is an integer, states are plain flags.
  bit          m_enable, m_cap, m_armed, m_ovf, m_busy, m_ack;
  logic [31:0] m_dat, m_trig_mask, m_trig_val;
  logic [PADS-1:0] m_mask, m_prev;
  int          m_ts;
  logic [63:0] m_q[$];

  function automatic bit model_mapped(input logic [31:0] a);
    if (a[31:8] != BASE_ADDR[31:8]) return 1'b0;
    if (a[1:0] != 2'b00) return 1'b0;
`ifdef IO_TRACE_TRIGGER_EN
    return a[7:0] <= 8'h1C;
`else
    return a[7:0] <= 8'h14;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] off);
    logic [63:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 64'd0;
    case (off)
      8'h00: return {31'd0, m_enable};
      8'h04: return m_mask[31:0];
      8'h08: return 32'(m_mask[PADS-1:32]);
      8'h0C: return 32'(m_q.size()) | (32'(m_q.size() == 0) << 16)
                    | (32'(m_q.size() == DEPTH) << 17) | (32'(m_ovf) << 18);
      8'h10: return h[31:0];
      8'h14: return h[63:32];
      8'h18: return m_trig_mask;
      8'h1C: return m_trig_val;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [7:0]  off;
    bit          acc, wrok, clr, pop, push, was_cap, entering;
    logic [31:0] rv;
    logic [63:0] e;
    off  = wbs_adr_i[7:0];
    acc  = wbs_cyc_i && wbs_stb_i && !m_busy && model_mapped(wbs_adr_i);
    wrok = acc && wbs_we_i && (wbs_sel_i == 4'hF);
    clr  = wrok && (off == 8'h00) && wbs_dat_i[1];
    pop  = acc && !wbs_we_i && (off == 8'h14);
    push = m_cap && (((io_sample ^ m_prev) & m_mask) != '0) && !clr;
    rv   = model_read(off);
    e    = (64'(m_ts) << PADS) | 64'(io_sample);

    m_ack = acc;
    m_dat = (acc && !wbs_we_i) ? rv : 32'd0;
    if (acc) m_busy = 1'b1;
    else if (!(wbs_cyc_i && wbs_stb_i)) m_busy = 1'b0;

    if (clr) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop && m_q.size() > 0) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else m_ovf = 1'b1;
      end
    end

    was_cap = m_cap;
    entering = 1'b0;
    if (m_cap) begin
      if (!m_enable) m_cap = 1'b0;
    end else if (m_armed) begin
      if (!m_enable) m_armed = 1'b0;
      else if ((io_sample[31:0] & m_trig_mask) == (m_trig_val & m_trig_mask)) begin
        m_armed = 1'b0;
        m_cap = 1'b1;
        entering = 1'b1;
      end
    end else if (m_enable) begin
`ifdef IO_TRACE_TRIGGER_EN
      m_armed = 1'b1;
`else
      m_cap = 1'b1;
      entering = 1'b1;
`endif
    end
    if (entering || clr) m_ts = 0;
    else if (was_cap) m_ts = (m_ts + 1) % (1 << TS_WIDTH);

    if (wrok) begin
      case (off)
        8'h00: m_enable = wbs_dat_i[0];
        8'h04: m_mask[31:0] = wbs_dat_i;
        8'h08: m_mask[PADS-1:32] = wbs_dat_i[PADS-33:0];
`ifdef IO_TRACE_TRIGGER_EN
        8'h18: m_trig_mask = wbs_dat_i;
        8'h1C: m_trig_val = wbs_dat_i;
`endif
        default: ;
      endcase
    end
    m_prev = io_sample;
  endtask

  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      m_enable = 0; m_cap = 0; m_armed = 0; m_ovf = 0; m_busy = 0; m_ack = 0;
      m_dat = '0; m_trig_mask = '0; m_trig_val = '0; m_mask = '0; m_prev = '0; m_ts = 0;
      m_q.delete();
    end else begin
      model_step();
    end
  end

  always @(negedge wb_clk_i) begin
    if (check_en && !wb_rst_i) begin
      checkOutput("cyc_ack", wbs_ack_o, m_ack);
      checkOutput("cyc_dat", wbs_dat_o, m_dat);
      checkOutput("cyc_capturing", capturing, m_cap);
    end
  end

  task automatic applyStimulus(input bit write, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] sel, input bit toggle_pad0,
                               output logic [31:0] rdata, output bit acked);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = write; wbs_sel_i = sel;
    wbs_adr_i = addr; wbs_dat_i = wdata;
    if (toggle_pad0) io_sample[0] = ~io_sample[0];
    acked = 0;
    rdata = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        acked = 1;
        rdata = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 4'hF;
  endtask

  task automatic reg_write(input logic [7:0] off, input logic [31:0] data);
    logic [31:0] d;
    bit a;
    applyStimulus(1, BASE_ADDR + 32'(off), data, 4'hF, 0, d, a);
    checkOutput("write_ack", a, 1);
  endtask

  task automatic read_check(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bit a;
    applyStimulus(0, BASE_ADDR + 32'(off), 0, 4'hF, 0, d, a);
    checkOutput({tag, "_ack"}, a, 1);
    checkOutput(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    bit a;
    int acks;
    bit found;

    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    bit a;
    int acks;
    bit found;

    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 0;
    check_en = 1;

    // reset asserted while a read is being acked
    @(negedge wb_clk_i);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE_ADDR + 32'h0C;
    @(negedge wb_clk_i);
    checkOutput("pre_rst_ack", wbs_ack_o, 1);
    #2 wb_rst_i = 1;
    #1;
    checkOutput("rst_ack", wbs_ack_o, 0);
    checkOutput("rst_dat", wbs_dat_o, 0);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    @(negedge wb_clk_i);
    wb_rst_i = 0;
    read_check("rst_status", 8'h0C, 32'h0001_0000);

    // basic capture: pad 8 rises at ts 5, unmasked pad 9 follows
    reg_write(8'h04, 32'h0000_0100);
    reg_write(8'h00, 32'h1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge wb_clk_i);
      if (m_cap && m_ts == 5) found = 1;
    end
    checkOutput("ts5_reached", found, 1);
    io_sample[8] = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    io_sample[9] = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    read_check("basic_status", 8'h0C, 32'h0000_0001);
    read_check("basic_lo", 8'h10, 32'h0000_0100);
    applyStimulus(0, BASE_ADDR + 32'h14, 0, 4'hF, 0, d, a);
    checkOutput("basic_hi_ack", a, 1);
    checkOutput("basic_ts", d >> (PADS - 32), 5);
    checkOutput("basic_io_hi", d[PADS-33:0], 0);
    read_check("basic_empty", 8'h0C, 32'h0001_0000);

    // overflow: 20 changes on pad 8, low byte tags each entry
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk_i);
      io_sample[7:0] = 8'(i + 1);
      io_sample[8] = ~io_sample[8];
    end
    read_check("ovf_status", 8'h0C, 32'h0006_0010);
    read_check("ovf_first", 8'h10, 32'h0000_0201);
    reg_write(8'h00, 32'h3);
    read_check("clear_status", 8'h0C, 32'h0001_0000);
    read_check("ctrl_read", 8'h00, 32'h0000_0001);

    // refill to full, then pop and push in the same cycle
    reg_write(8'h04, 32'h0000_0001);
    for (int i = 0; i < 16; i++) begin
      @(negedge wb_clk_i);
      io_sample[0] = ~io_sample[0];
    end
    read_check("refill_status", 8'h0C, 32'h0002_0010);
    applyStimulus(0, BASE_ADDR + 32'h14, 0, 4'hF, 1, d, a);
    checkOutput("pushpop_ack", a, 1);
    read_check("pushpop_status", 8'h0C, 32'h0002_0010);

    // held strobe on DATA_HI for four cycles
    @(negedge wb_clk_i);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE_ADDR + 32'h14;
    acks = 0;
    repeat (4) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) acks++;
    end
    wbs_cyc_i = 0; wbs_stb_i = 0;
    checkOutput("held_acks", acks, 1);
    read_check("held_status", 8'h0C, 32'h0000_000F);

    // partial write is acked but ignored; MASK_HI keeps only PADS-32 bits
    applyStimulus(1, BASE_ADDR + 32'h04, 32'hFFFF_FFFF, 4'h1, 0, d, a);
    checkOutput("partial_ack", a, 1);
    read_check("partial_mask", 8'h04, 32'h0000_0001);
    reg_write(8'h08, 32'hFFFF_FFFF);
    read_check("mask_hi", 8'h08, 32'((64'd1 << (PADS - 32)) - 1));
    reg_write(8'h08, 32'h0);

    // unmapped and out-of-window accesses
    applyStimulus(0, BASE_ADDR + 32'h40, 0, 4'hF, 0, d, a);
    checkOutput("unmapped_ack", a, 0);
    applyStimulus(0, BASE_ADDR + 32'h100, 0, 4'hF, 0, d, a);
    checkOutput("outwin_ack", a, 0);
    applyStimulus(0, BASE_ADDR + 32'h18, 0, 4'hF, 0, d, a);
`ifdef IO_TRACE_TRIGGER_EN
    checkOutput("trig_reg_ack", a, 1);
`else
    checkOutput("off18_ack", a, 0);
`endif

    // disable keeps the FIFO
    reg_write(8'h00, 32'h0);
    repeat (2) @(negedge wb_clk_i);
    checkOutput("idle_capturing", capturing, 0);
    read_check("idle_status", 8'h0C, 32'h0000_000F);

    // random pad activity with interleaved register reads
    reg_write(8'h04, $urandom);
    reg_write(8'h08, $urandom);
    reg_write(8'h00, 32'h3);
    for (int i = 0; i < 150; i++) begin
      int r;
      logic [PADS-1:0] flip;
      r = $urandom_range(0, 3);
      if (r == 0) begin
        case ($urandom_range(0, 2))
          0: applyStimulus(0, BASE_ADDR + 32'h0C, 0, 4'hF, 0, d, a);
          1: applyStimulus(0, BASE_ADDR + 32'h10, 0, 4'hF, 0, d, a);
          default: applyStimulus(0, BASE_ADDR + 32'h14, 0, 4'hF, 0, d, a);
        endcase
      end else begin
        @(negedge wb_clk_i);
        flip = PADS'({$urandom, $urandom}) & PADS'({$urandom, $urandom});
        if (r != 1) io_sample = io_sample ^ flip;
      end
    end
    reg_write(8'h00, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(0, BASE_ADDR + 32'h10, 0, 4'hF, 0, d, a);
      applyStimulus(0, BASE_ADDR + 32'h14, 0, 4'hF, 0, d, a);
    end
    applyStimulus(0, BASE_ADDR + 32'h0C, 0, 4'hF, 0, d, a);
    checkOutput("drain_empty", d[16], 1);
    read_check("drain_hi_zero", 8'h14, 32'h0);
    read_check("drain_lo_zero", 8'h10, 32'h0);

`ifdef IO_TRACE_TRIGGER_EN
    // trigger: pads [11:8] == 5 starts capture
    @(negedge wb_clk_i);
    io_sample = '0;
    reg_write(8'h18, 32'h0000_0F00);
    reg_write(8'h1C, 32'h0000_0500);
    reg_write(8'h04, 32'h0000_00FF);
    reg_write(8'h08, 32'h0);
    reg_write(8'h00, 32'h3);
    repeat (4) begin
      @(negedge wb_clk_i);
      io_sample[0] = ~io_sample[0];
    end
    checkOutput("armed_capturing", capturing, 0);
    read_check("armed_status", 8'h0C, 32'h0001_0000);
    @(negedge wb_clk_i);
    io_sample[11:8] = 4'h5;
    @(negedge wb_clk_i);
    checkOutput("trig_capturing", capturing, 1);
    io_sample[1] = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    read_check("trig_status", 8'h0C, 32'h0000_0001);
    read_check("trig_lo", 8'h10, 32'h0000_0502);
    read_check("trig_hi", 8'h14, 32'h0);
`endif

    repeat (2) @(negedge wb_clk_i);
    check_en = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
